// File: rtl/usbf_utmi_phy.sv
// usbf_utmi_phy: UTMI PHY-side byte endpoint pacing TX and sourcing RX; define USBF_PHY_LOOPBACK_EN to replay TX packets on RX
module usbf_utmi_phy #(
  parameter int FS_DIV   = 40,
  parameter int SYNC_CYC = 4,
  parameter int EOP_CYC  = 2
) (
  input  logic        phy_clk,
  input  logic        rst,
  input  logic [7:0]  DataOut,
  input  logic        TxValid,
  output logic        TxReady,
  output logic [7:0]  DataIn,
  output logic        RxValid,
  output logic        RxActive,
  output logic        RxError,
  input  logic        XcvSelect,
  input  logic [1:0]  OpMode,
  output logic [1:0]  LineState,
  input  logic [1:0]  ls_host,
  input  logic [7:0]  rx_inj_data,
  input  logic        rx_inj_valid,
  input  logic        rx_inj_last,
  input  logic        rx_inj_err,
  output logic        rx_inj_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_byte_valid,
  output logic        tx_pkt_done,
  output logic [10:0] tx_pkt_len
);
  typedef enum logic [1:0] {TX_IDLE, TX_SYNC, TX_DATA, TX_EOP} tx_st_t;
  typedef enum logic [1:0] {RX_IDLE, RX_SYNC, RX_DATA, RX_EOP} rx_st_t;
  localparam logic [15:0] FS_M = 16'(FS_DIV - 1);
  localparam logic [15:0] SY_M = 16'(SYNC_CYC - 1);
  localparam logic [15:0] EO_M = 16'(EOP_CYC - 1);
  tx_st_t tx_q, tx_d;
  rx_st_t rx_q, rx_d;
  logic [15:0] tc_q, tc_d, rc_q, rc_d;
  logic [10:0] len_q, len_d, pkt_len_q;
  logic [7:0] tx_byte_q, src_data;
  logic [1:0] ls_q;
  logic tbv_q, done_q, done_d;
  logic t_bnd, r_bnd, r_pop, cap, rx_go, tx_go;
  logic src_vld, src_last, src_err, rp_rdy, rp_blk, rp_act;

  assign t_bnd = !XcvSelect || tc_q == FS_M;
  assign r_bnd = !XcvSelect || rc_q == FS_M;
  assign TxReady = tx_q == TX_DATA && t_bnd;
  assign cap = TxReady && TxValid;
  assign rx_go = rx_q == RX_IDLE && tx_q == TX_IDLE && (rp_blk ? rp_rdy : rx_inj_valid);
  assign tx_go = tx_q == TX_IDLE && rx_q == RX_IDLE && TxValid && !rx_go && !rp_blk;
  assign r_pop = rx_q == RX_DATA && r_bnd;
  assign rx_inj_ready = r_pop && !rp_act;
  assign RxValid = r_pop && src_vld && !src_err;
  assign RxError = r_pop && !(src_vld && !src_err);
  assign DataIn = RxValid ? src_data : 8'h00;
  assign RxActive = rx_q != RX_IDLE;
  assign LineState = (tx_q != TX_IDLE && OpMode == 2'b10) ? 2'b10 : ls_q;
  assign tx_byte = tx_byte_q;
  assign tx_byte_valid = tbv_q;
  assign tx_pkt_done = done_q;
  assign tx_pkt_len = pkt_len_q;

`ifdef USBF_PHY_LOOPBACK_EN
  logic [7:0] buf_q [64];
  logic [6:0] rp_idx_q;
  logic [10:0] rp_len_q;
  logic [15:0] rp_dly_q;
  logic rp_pend_q, rp_act_q;
  assign rp_act = rp_act_q;
  assign rp_blk = rp_pend_q;
  assign rp_rdy = rp_pend_q && rp_dly_q == 16'd0;
  assign src_vld = rp_act_q || rx_inj_valid;
  assign src_err = rp_act_q ? rp_idx_q[6] : rx_inj_err;
  assign src_data = rp_act_q ? buf_q[rp_idx_q[5:0]] : rx_inj_data;
  assign src_last = rp_act_q ? (rp_idx_q[6] || {4'd0, rp_idx_q} == rp_len_q - 11'd1) : rx_inj_last;
  // capture the first 64 bytes of each TX packet for replay
  always_ff @(posedge phy_clk)
    if (cap && len_q < 11'd64) buf_q[len_q[5:0]] <= DataOut;
  // schedule replay after a completed non-empty packet and walk the buffer while it plays
  always_ff @(posedge phy_clk or negedge rst)
    if (!rst) begin
      rp_pend_q <= 1'b0;
      rp_act_q <= 1'b0;
      rp_idx_q <= '0;
      rp_len_q <= '0;
      rp_dly_q <= '0;
    end else begin
      if (done_d && len_q != 11'd0) begin
        rp_pend_q <= 1'b1;
        rp_dly_q <= 16'(EOP_CYC);
        rp_len_q <= len_q;
      end else if (rp_dly_q != 16'd0) rp_dly_q <= rp_dly_q - 16'd1;
      if (rx_go && rp_rdy) begin
        rp_act_q <= 1'b1;
        rp_pend_q <= 1'b0;
        rp_idx_q <= '0;
      end else if (rp_act_q && r_pop) rp_idx_q <= rp_idx_q + 7'd1;
      if (rx_q != RX_IDLE && rx_d == RX_IDLE) rp_act_q <= 1'b0;
    end
`else
  assign rp_act = 1'b0;
  assign rp_blk = 1'b0;
  assign rp_rdy = 1'b0;
  assign src_vld = rx_inj_valid;
  assign src_err = rx_inj_err;
  assign src_data = rx_inj_data;
  assign src_last = rx_inj_last;
`endif

  // TX next state, byte-time counter and saturating length
  always_comb begin
    tx_d = tx_q;
    done_d = 1'b0;
    case (tx_q)
      TX_IDLE: tx_d = tx_go ? TX_SYNC : TX_IDLE;
      TX_SYNC: tx_d = tc_q == SY_M ? TX_DATA : TX_SYNC;
      TX_DATA: tx_d = (TxReady && !TxValid) ? TX_EOP : TX_DATA;
      default: begin
        tx_d = tc_q == EO_M ? TX_IDLE : TX_EOP;
        done_d = tc_q == EO_M;
      end
    endcase
    tc_d = (tx_d != tx_q || tx_q == TX_IDLE || (tx_q == TX_DATA && t_bnd)) ? '0 : tc_q + 16'd1;
    len_d = done_d ? '0 : (cap && len_q != 11'h7FF) ? len_q + 11'd1 : len_q;
  end

  // TX state, capture monitor and end-of-packet report
  always_ff @(posedge phy_clk or negedge rst)
    if (!rst) begin
      tx_q <= TX_IDLE;
      tc_q <= '0;
      len_q <= '0;
      done_q <= 1'b0;
      tbv_q <= 1'b0;
      tx_byte_q <= '0;
      pkt_len_q <= '0;
    end else begin
      tx_q <= tx_d;
      tc_q <= tc_d;
      len_q <= len_d;
      done_q <= done_d;
      tbv_q <= cap;
      if (cap) tx_byte_q <= DataOut;
      if (done_d) pkt_len_q <= len_q;
    end

  // RX next state and byte-time counter
  always_comb begin
    rx_d = rx_q;
    case (rx_q)
      RX_IDLE: rx_d = rx_go ? RX_SYNC : RX_IDLE;
      RX_SYNC: rx_d = rc_q == SY_M ? RX_DATA : RX_SYNC;
      RX_DATA: rx_d = (r_pop && (!src_vld || src_last)) ? RX_EOP : RX_DATA;
      default: rx_d = rc_q == EO_M ? RX_IDLE : RX_EOP;
    endcase
    rc_d = (rx_d != rx_q || rx_q == RX_IDLE || r_pop) ? '0 : rc_q + 16'd1;
  end

  // RX state and registered host line state
  always_ff @(posedge phy_clk or negedge rst)
    if (!rst) begin
      rx_q <= RX_IDLE;
      rc_q <= '0;
      ls_q <= 2'b00;
    end else begin
      rx_q <= rx_d;
      rc_q <= rc_d;
      ls_q <= ls_host;
    end
endmodule

// File: tb/tb_usbf_utmi_phy.sv
// tb_usbf_utmi_phy: scoreboard bench for the UTMI PHY endpoint
module tb_usbf_utmi_phy;
  logic phy_clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] DataOut = '0;
  logic TxValid = 1'b0;
  logic TxReady;
  logic [7:0] DataIn;
  logic RxValid, RxActive, RxError;
  logic XcvSelect = 1'b0;
  logic [1:0] OpMode = 2'b00;
  logic [1:0] LineState;
  logic [1:0] ls_host = 2'b00;
  logic [7:0] rx_inj_data = '0;
  logic rx_inj_valid = 1'b0, rx_inj_last = 1'b0, rx_inj_err = 1'b0;
  logic rx_inj_ready;
  logic [7:0] tx_byte;
  logic tx_byte_valid, tx_pkt_done;
  logic [10:0] tx_pkt_len;

  int checks = 0, errors = 0, cyc = 0, done_cnt = 0, overlap = 0;
  logic [7:0] tx_exp[$];
  logic [8:0] rx_exp[$];
  logic [7:0] txv[$];
  int rk[$];
  logic [7:0] rd[$];
  int rdy_cyc[$];
  int rxv_cyc[$];

  usbf_utmi_phy dut (
    .phy_clk(phy_clk), .rst(rst), .DataOut(DataOut), .TxValid(TxValid), .TxReady(TxReady),
    .DataIn(DataIn), .RxValid(RxValid), .RxActive(RxActive), .RxError(RxError),
    .XcvSelect(XcvSelect), .OpMode(OpMode), .LineState(LineState), .ls_host(ls_host),
    .rx_inj_data(rx_inj_data), .rx_inj_valid(rx_inj_valid), .rx_inj_last(rx_inj_last),
    .rx_inj_err(rx_inj_err), .rx_inj_ready(rx_inj_ready), .tx_byte(tx_byte),
    .tx_byte_valid(tx_byte_valid), .tx_pkt_done(tx_pkt_done), .tx_pkt_len(tx_pkt_len)
  );

  always #5 phy_clk = ~phy_clk;
  always @(posedge phy_clk) cyc++;

  always @(negedge phy_clk) begin
    if (tx_pkt_done) done_cnt++;
    if (rst && TxReady && RxActive) overlap++;
    if (rst && tx_byte_valid) begin
      checks++;
      if (tx_exp.size() == 0) begin
        errors++;
        $display("FAIL tx_byte unexpected: got %h, none expected", tx_byte);
      end else begin
        logic [7:0] e;
        e = tx_exp.pop_front();
        if (tx_byte !== e) begin
          errors++;
          $display("FAIL tx_byte: got %h expected %h", tx_byte, e);
        end
      end
    end
    if (rst && (RxValid || RxError)) begin
      logic [8:0] g;
      g = {RxError, RxValid ? DataIn : 8'h00};
      checks++;
      if (RxValid) rxv_cyc.push_back(cyc);
      if (rx_exp.size() == 0) begin
        errors++;
        $display("FAIL rx_event unexpected: got %h, none expected", g);
      end else begin
        logic [8:0] e;
        e = rx_exp.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL rx_event: got %h expected %h", g, e);
        end
      end
    end
  end

  task automatic tx_send(output int c_start, output int c_first, output int c_end);
    int i = 0, b = 0, n = txv.size();
    c_first = -1;
    c_end = -1;
    rdy_cyc.delete();
    @(negedge phy_clk);
    c_start = cyc;
    while (b < 6000) begin
      TxValid = i < n;
      DataOut = i < n ? txv[i] : 8'h00;
      if (TxReady) begin
        rdy_cyc.push_back(cyc);
        if (c_first < 0) c_first = cyc;
        if (i == n) begin
          c_end = cyc;
          break;
        end
        tx_exp.push_back(txv[i]);
`ifdef USBF_PHY_LOOPBACK_EN
        if (i < 64) rx_exp.push_back({1'b0, txv[i]});
        else if (i == 64) rx_exp.push_back(9'h100);
`endif
        i++;
      end
      @(negedge phy_clk);
      b++;
    end
    TxValid = 1'b0;
  endtask

  task automatic rx_send(output int c_act, output int c_done);
    int i = 0, b = 0, n = rk.size();
    c_act = -1;
    c_done = -1;
    rxv_cyc.delete();
    @(negedge phy_clk);
    while (b < 3000) begin
      rx_inj_valid = i < n && rk[i] != 2;
      rx_inj_err = i < n && rk[i] == 1;
      rx_inj_last = i == n - 1;
      rx_inj_data = i < n ? rd[i] : 8'h00;
      if (RxActive && c_act < 0) c_act = cyc;
      if (c_act >= 0 && !RxActive) begin
        c_done = cyc;
        break;
      end
      if (rx_inj_ready && i < n) begin
        rx_exp.push_back(rk[i] == 0 ? {1'b0, rd[i]} : 9'h100);
        i++;
      end
      @(negedge phy_clk);
      b++;
    end
    rx_inj_valid = 1'b0;
    rx_inj_err = 1'b0;
    rx_inj_last = 1'b0;
  endtask

  task automatic wait_done(output int c);
    int b = 0;
    c = -1;
    while (b < 500) begin
      if (tx_pkt_done) begin
        c = cyc;
        break;
      end
      @(negedge phy_clk);
      b++;
    end
  endtask

  task automatic settle();
    int b = 0;
    repeat (3) @(negedge phy_clk);
    while ((RxActive || rx_exp.size() != 0) && b < 600) begin
      @(negedge phy_clk);
      b++;
    end
    repeat (2) @(negedge phy_clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge phy_clk);
    checks++;
    if ({TxReady, DataIn, RxValid, RxActive, RxError, rx_inj_ready} !== '0) begin
      errors++;
      $display("FAIL reset_link_outputs: got %b expected 0", {TxReady, DataIn, RxValid, RxActive, RxError, rx_inj_ready});
    end
    checks++;
    if ({LineState, tx_byte, tx_byte_valid, tx_pkt_done, tx_pkt_len} !== '0) begin
      errors++;
      $display("FAIL reset_monitor_outputs: got %h expected 0", {LineState, tx_byte, tx_byte_valid, tx_pkt_done, tx_pkt_len});
    end
    rst = 1'b1;
    repeat (2) @(negedge phy_clk);
  endtask

  task automatic test_hs_tx();
    int cs, cf, ce, cd;
    txv = '{8'hA5, 8'hC3, 8'h3C};
    tx_send(cs, cf, ce);
    wait_done(cd);
    checks++;
    if (cf - cs !== 5) begin errors++; $display("FAIL hs_first_ready: got %0d expected 5", cf - cs); end
    checks++;
    if (cd - ce !== 3) begin errors++; $display("FAIL hs_done_latency: got %0d expected 3", cd - ce); end
    checks++;
    if (tx_pkt_len !== 11'd3) begin errors++; $display("FAIL hs_pkt_len: got %0d expected 3", tx_pkt_len); end
    checks++;
    if (tx_exp.size() !== 0) begin errors++; $display("FAIL hs_bytes_left: got %0d expected 0", tx_exp.size()); end
    settle();
  endtask

  task automatic test_fs_tx();
    int cs, cf, ce, cd;
    XcvSelect = 1'b1;
    txv = '{8'h5A, 8'h96};
    tx_send(cs, cf, ce);
    wait_done(cd);
    checks++;
    if (rdy_cyc.size() !== 3) begin
      errors++;
      $display("FAIL fs_ready_count: got %0d expected 3", rdy_cyc.size());
    end else begin
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (rdy_cyc[k] - rdy_cyc[k-1] !== 40) begin
          errors++;
          $display("FAIL fs_ready_spacing: got %0d expected 40", rdy_cyc[k] - rdy_cyc[k-1]);
        end
      end
    end
    checks++;
    if (tx_pkt_len !== 11'd2) begin errors++; $display("FAIL fs_pkt_len: got %0d expected 2", tx_pkt_len); end
    settle();
    XcvSelect = 1'b0;
  endtask

  task automatic test_rx_basic();
    int ca, cd;
    rk = '{0, 0, 0};
    rd = '{8'h2D, 8'h00, 8'h10};
    rx_send(ca, cd);
    checks++;
    if (cd - ca !== 9) begin errors++; $display("FAIL rx_active_len: got %0d expected 9", cd - ca); end
    checks++;
    if (rxv_cyc.size() !== 3) begin
      errors++;
      $display("FAIL rx_valid_count: got %0d expected 3", rxv_cyc.size());
    end else begin
      checks++;
      if (rxv_cyc[0] - ca !== 4) begin errors++; $display("FAIL rx_first_valid: got %0d expected 4", rxv_cyc[0] - ca); end
      checks++;
      if (rxv_cyc[2] - rxv_cyc[0] !== 2) begin errors++; $display("FAIL rx_consecutive: got %0d expected 2", rxv_cyc[2] - rxv_cyc[0]); end
    end
    settle();
  endtask

  task automatic test_rx_error();
    int ca, cd;
    rk = '{0, 1, 0};
    rd = '{8'h11, 8'hEE, 8'h22};
    rx_send(ca, cd);
    checks++;
    if (cd - ca !== 9) begin errors++; $display("FAIL rxerr_active_len: got %0d expected 9", cd - ca); end
    checks++;
    if (rxv_cyc.size() !== 2) begin errors++; $display("FAIL rxerr_valid_count: got %0d expected 2", rxv_cyc.size()); end
    settle();
  endtask

  task automatic test_rx_underrun();
    int ca, cd;
    rk = '{0, 2};
    rd = '{8'h33, 8'h00};
    rx_send(ca, cd);
    checks++;
    if (cd - ca !== 8) begin errors++; $display("FAIL underrun_active_len: got %0d expected 8", cd - ca); end
    settle();
  endtask

  task automatic test_back_to_back();
    int cs, cf, ce, cd, ca, cr, ov0;
    ov0 = overlap;
    txv = '{8'h81, 8'h42};
    rk = '{0, 0};
    rd = '{8'h99, 8'h66};
    fork
      tx_send(cs, cf, ce);
      rx_send(ca, cr);
    join
    wait_done(cd);
    checks++;
    if (!(cr > 0 && cf > cr)) begin errors++; $display("FAIL b2b_rx_first: tx ready at %0d, rx done at %0d", cf, cr); end
    checks++;
    if (overlap !== ov0) begin errors++; $display("FAIL b2b_overlap: got %0d expected %0d", overlap, ov0); end
    checks++;
    if (tx_pkt_len !== 11'd2) begin errors++; $display("FAIL b2b_pkt_len: got %0d expected 2", tx_pkt_len); end
    settle();
  endtask

  task automatic test_linestate();
    int cs, cf, ce, cd, bad = 0;
    ls_host = 2'b01;
    repeat (2) @(negedge phy_clk);
    ls_host = 2'b11;
    #1;
    checks++;
    if (LineState !== 2'b01) begin errors++; $display("FAIL ls_registered: got %b expected 01", LineState); end
    @(negedge phy_clk);
    checks++;
    if (LineState !== 2'b11) begin errors++; $display("FAIL ls_follow: got %b expected 11", LineState); end
    ls_host = 2'b01;
    OpMode = 2'b10;
    @(negedge phy_clk);
    txv = '{8'h00, 8'h00};
    fork
      begin
        tx_send(cs, cf, ce);
        wait_done(cd);
      end
      begin
        int b = 0;
        @(negedge phy_clk);
        while (b < 500) begin
          @(negedge phy_clk);
          b++;
          if (tx_pkt_done) break;
          if (LineState !== 2'b10) bad++;
        end
      end
    join
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL ls_chirp_k: got %0d non-K cycles expected 0", bad); end
    checks++;
    if (LineState !== 2'b01) begin errors++; $display("FAIL ls_after_tx: got %b expected 01", LineState); end
    settle();
    OpMode = 2'b00;
    ls_host = 2'b00;
  endtask

  task automatic test_reset_mid();
    int n = 0, b = 0, d0;
    @(negedge phy_clk);
    TxValid = 1'b1;
    DataOut = 8'h77;
    while (n < 2 && b < 200) begin
      if (TxReady) begin
        tx_exp.push_back(8'h77);
        n++;
      end
      if (n < 2) @(negedge phy_clk);
      b++;
    end
    @(negedge phy_clk);
    rst = 1'b0;
    TxValid = 1'b0;
    #1;
    checks++;
    if ({TxReady, DataIn, RxValid, RxActive, RxError, rx_inj_ready, LineState, tx_byte, tx_byte_valid, tx_pkt_done, tx_pkt_len} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %h expected 0", {TxReady, DataIn, RxValid, RxActive, RxError, rx_inj_ready, LineState, tx_byte, tx_byte_valid, tx_pkt_done, tx_pkt_len});
    end
    tx_exp.delete();
    repeat (2) @(negedge phy_clk);
    rst = 1'b1;
    d0 = done_cnt;
    repeat (20) @(negedge phy_clk);
    checks++;
    if (done_cnt !== d0) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", done_cnt - d0); end
  endtask

  task automatic test_saturation();
    int cs, cf, ce, cd;
    txv.delete();
    for (int k = 0; k < 2050; k++) txv.push_back(8'(k * 7 + 3));
    tx_send(cs, cf, ce);
    wait_done(cd);
    checks++;
    if (tx_pkt_len !== 11'd2047) begin errors++; $display("FAIL sat_pkt_len: got %0d expected 2047", tx_pkt_len); end
    checks++;
    if (rdy_cyc.size() !== 2051) begin errors++; $display("FAIL sat_ready_count: got %0d expected 2051", rdy_cyc.size()); end
    settle();
  endtask

  task automatic test_loopback();
`ifdef USBF_PHY_LOOPBACK_EN
    int cs, cf, ce, cd, b = 0, inj = 0;
    txv = '{8'hA1, 8'hB2, 8'hC3};
    rxv_cyc.delete();
    tx_send(cs, cf, ce);
    wait_done(cd);
    while (!RxActive && b < 100) begin @(negedge phy_clk); b++; end
    while (RxActive && b < 300) begin
      if (rx_inj_ready) inj++;
      @(negedge phy_clk);
      b++;
    end
    checks++;
    if (rxv_cyc.size() !== 3) begin errors++; $display("FAIL loop_replay_count: got %0d expected 3", rxv_cyc.size()); end
    checks++;
    if (inj !== 0) begin errors++; $display("FAIL loop_inj_ready: got %0d expected 0", inj); end
    settle();
`endif
  endtask

  initial begin
    test_reset();
    test_hs_tx();
    test_fs_tx();
    test_rx_basic();
    test_rx_error();
    test_rx_underrun();
    test_back_to_back();
    test_linestate();
    test_reset_mid();
    test_saturation();
    test_loopback();
    settle();
    checks++;
    if (tx_exp.size() !== 0) begin errors++; $display("FAIL tx_scoreboard_left: got %0d expected 0", tx_exp.size()); end
    checks++;
    if (rx_exp.size() !== 0) begin errors++; $display("FAIL rx_scoreboard_left: got %0d expected 0", rx_exp.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
